// File: rtl/gate_pkg.sv
// Shared definitions for the gate_checker harness: operation codes, FSM
// state type and the reference truth function used to judge a gate.
package gate_pkg;

  // Widest gate the reference function understands.
  localparam int unsigned MaxIn = 4;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  function automatic logic op_reserved(input logic [2:0] op);
    return op > OP_XNOR;
  endfunction

  // Reference output of an n_in-input gate; bits of vec at or above n_in
  // are ignored so the reductions only see the swept inputs.
  function automatic logic gate_expected(input logic [2:0]       op,
                                         input logic [MaxIn-1:0] vec,
                                         input int unsigned      n_in);
    logic red_and;
    logic red_or;
    logic red_xor;
    logic res;
    red_and = 1'b1;
    red_or  = 1'b0;
    red_xor = 1'b0;
    for (int unsigned i = 0; i < MaxIn; i++) begin
      if (i < n_in) begin
        red_and = red_and & vec[i];
        red_or  = red_or | vec[i];
        red_xor = red_xor ^ vec[i];
      end
    end
    case (op)
      OP_AND:  res = red_and;
      OP_OR:   res = red_or;
      OP_NAND: res = ~red_and;
      OP_NOR:  res = ~red_or;
      OP_XOR:  res = red_xor;
      OP_XNOR: res = ~red_xor;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_ref.sv
// Combinational reference model of a small logic gate.
//   op_i  : operation code (gate_pkg OP_*)
//   vec_i : gate input vector, bit 0 is in1
//   exp_o : expected gate output (0 for reserved codes)
module gate_ref
  import gate_pkg::*;
#(
  parameter int unsigned NIn = 2
) (
  input  logic [2:0]     op_i,
  input  logic [NIn-1:0] vec_i,
  output logic           exp_o
);

  logic [MaxIn-1:0] vec_pad;

  assign vec_pad = MaxIn'(vec_i);
  assign exp_o   = gate_expected(op_i, vec_pad, NIn);

endmodule

// File: rtl/gate_checker.sv
// Self-checking sweep harness for a combinational gate. On start it drives
// every input vector in turn, holds each for SETTLE_CYCLES, samples the gate
// output and compares it against the reference for the latched op.
//   clk, rst_n  : clock, synchronous active-low reset
//   start, op   : launch a sweep with the given function (accepted in idle)
//   vec         : vector driven to the gate under test
//   dut_out     : gate under test output
//   busy, done  : sweep in progress / one-cycle end-of-sweep pulse
//   pass,bad_op : all vectors matched / latched op was reserved
//   result      : per-vector match bitmap
//   err_count   : number of mismatching vectors
module gate_checker
  import gate_pkg::*;
#(
  parameter int unsigned N_IN          = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  output logic [N_IN-1:0]     vec,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                bad_op,
  output logic [2**N_IN-1:0]  result,
  output logic [N_IN:0]       err_count
);

  localparam int unsigned V    = 2 ** N_IN;
  localparam int unsigned ErrW = N_IN + 1;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [V-1:0]        result_q, result_d;
  logic [ErrW-1:0]     err_q, err_d;
  logic                pass_q, pass_d;
  logic                bad_op_q, bad_op_d;
  logic                exp_bit;
  logic                match;

  gate_ref #(
    .NIn (N_IN)
  ) u_ref (
    .op_i  (op_q),
    .vec_i (vec_q),
    .exp_o (exp_bit)
  );

  assign match = (exp_bit == dut_out);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    pass_d   = pass_q;
    bad_op_d = bad_op_q;

    unique case (state_q)
      StIdle: begin
        vec_d = '0;
        if (start) begin
          op_d     = op;
          result_d = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          bad_op_d = 1'b0;
          cnt_d    = '0;
          if (op_reserved(op)) begin
            bad_op_d = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StSettle;
          end
        end
      end

      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StSample: begin
        result_d[vec_q] = match;
        if (!match) begin
          err_d = err_q + ErrW'(1);
        end
        if (vec_q == N_IN'(V - 1)) begin
          // Verdict uses the count including this final vector.
          vec_d   = '0;
          pass_d  = (err_d == '0) && !bad_op_q;
          state_d = StDone;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = StSettle;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      bad_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      bad_op_q <= bad_op_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign bad_op    = bad_op_q;
  assign result    = result_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: a 2-input instance (S=1) checking an AND
// gate or a constant-1 driver, and a 3-input instance (S=3) checking XOR.
module tb_gate_checker;

  logic       clk;
  logic       rst_n;

  logic       start_a, start_b;
  logic [2:0] op_a, op_b;
  logic [1:0] vec_a;
  logic [2:0] vec_b;
  logic       dut_out_a, dut_out_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, bad_op_a, bad_op_b;
  logic [3:0] result_a;
  logic [7:0] result_b;
  logic [2:0] err_a;
  logic [3:0] err_b;

  logic       tie_one;   // 0: gate A is AND of vec, 1: gate A output tied to 1

  int         total;
  int         bad;
  logic [3:0] vec_log [0:63];
  int         done_cyc;
  int         ndone;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_out_a = tie_one ? 1'b1 : (vec_a[0] & vec_a[1]);
  assign dut_out_b = vec_b[0] ^ vec_b[1] ^ vec_b[2];

  gate_checker #(
    .N_IN          (2),
    .SETTLE_CYCLES (1)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .op        (op_a),
    .vec       (vec_a),
    .dut_out   (dut_out_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .bad_op    (bad_op_a),
    .result    (result_a),
    .err_count (err_a)
  );

  gate_checker #(
    .N_IN          (3),
    .SETTLE_CYCLES (3)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .op        (op_b),
    .vec       (vec_b),
    .dut_out   (dut_out_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .bad_op    (bad_op_b),
    .result    (result_b),
    .err_count (err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch a sweep (start sampled at edge 0) and watch cycles 1..budget at the
  // falling edge; op is changed to op_after right after acceptance, and start
  // is pulsed again in cycle pulse_cyc (0 = never).
  task automatic sweep(input bit sel_b, input logic [2:0] op_v, input logic [2:0] op_after,
                       input int budget, input int pulse_cyc,
                       output int d_cyc, output int n_done);
    logic dn;
    d_cyc  = -1;
    n_done = 0;
    @(negedge clk);
    if (sel_b) begin
      op_b    = op_v;
      start_b = 1'b1;
    end else begin
      op_a    = op_v;
      start_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel_b) op_b = op_after;
    else       op_a = op_after;
    for (int c = 1; c <= budget; c++) begin
      dn = sel_b ? done_b : done_a;
      vec_log[c] = sel_b ? 4'(vec_b) : 4'(vec_a);
      if (dn) begin
        n_done++;
        if (d_cyc < 0) d_cyc = c;
      end
      if (sel_b) start_b = (c == pulse_cyc);
      else       start_a = (c == pulse_cyc);
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    op_a    = 3'd0;
    op_b    = 3'd0;
    tie_one = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy",   {31'd0, busy_a},   32'd0);
    check("rst_done",   {31'd0, done_a},   32'd0);
    check("rst_pass",   {31'd0, pass_a},   32'd0);
    check("rst_result", {28'd0, result_a}, 32'd0);
    check("rst_err",    {29'd0, err_a},    32'd0);
    check("rst_vec",    {30'd0, vec_a},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AND gate checked as AND; op flipped to XNOR afterwards must not matter
    sweep(1'b0, 3'd0, 3'd5, 12, 0, done_cyc, ndone);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("and_vec_c%0d", c), {28'd0, vec_log[c]}, 32'((c - 1) / 2));
    end
    check("and_done_cyc", done_cyc, 32'd9);
    check("and_ndone",    ndone,    32'd1);
    check("and_result",   {28'd0, result_a}, 32'h0000000f);
    check("and_err",      {29'd0, err_a},    32'd0);
    check("and_pass",     {31'd0, pass_a},   32'd1);
    check("and_busy_end", {31'd0, busy_a},   32'd0);

    // AND gate checked as OR: vectors 1 and 2 mismatch
    sweep(1'b0, 3'd1, 3'd0, 12, 0, done_cyc, ndone);
    check("or_done_cyc", done_cyc, 32'd9);
    check("or_result",   {28'd0, result_a}, 32'h00000009);
    check("or_err",      {29'd0, err_a},    32'd2);
    check("or_pass",     {31'd0, pass_a},   32'd0);

    // Output tied high checked as NAND, start pulsed mid-sweep is ignored
    tie_one = 1'b1;
    sweep(1'b0, 3'd2, 3'd2, 20, 4, done_cyc, ndone);
    check("nand_done_cyc", done_cyc, 32'd9);
    check("nand_ndone",    ndone,    32'd1);
    check("nand_result",   {28'd0, result_a}, 32'h00000007);
    check("nand_err",      {29'd0, err_a},    32'd1);
    check("nand_pass",     {31'd0, pass_a},   32'd0);
    tie_one = 1'b0;

    // Reserved op
    sweep(1'b0, 3'd6, 3'd0, 6, 0, done_cyc, ndone);
    check("rsv_done_cyc", done_cyc, 32'd1);
    check("rsv_ndone",    ndone,    32'd1);
    check("rsv_vec",      {28'd0, vec_log[1]}, 32'd0);
    check("rsv_bad_op",   {31'd0, bad_op_a},   32'd1);
    check("rsv_pass",     {31'd0, pass_a},     32'd0);
    check("rsv_result",   {28'd0, result_a},   32'd0);
    check("rsv_err",      {29'd0, err_a},      32'd0);

    // Reset during the settle phase of vector 2
    @(negedge clk);
    op_a    = 3'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_vec",    {30'd0, vec_a},    32'd2);
    check("mid_result", {28'd0, result_a}, 32'h00000003);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy",   {31'd0, busy_a},   32'd0);
    check("mrst_done",   {31'd0, done_a},   32'd0);
    check("mrst_vec",    {30'd0, vec_a},    32'd0);
    check("mrst_result", {28'd0, result_a}, 32'd0);
    check("mrst_err",    {29'd0, err_a},    32'd0);
    check("mrst_bad_op", {31'd0, bad_op_a}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_a) ndone++;
      @(negedge clk);
    end
    check("mrst_no_done", ndone, 32'd0);
    sweep(1'b0, 3'd0, 3'd0, 12, 0, done_cyc, ndone);
    check("fresh_done_cyc", done_cyc, 32'd9);
    check("fresh_result",   {28'd0, result_a}, 32'h0000000f);
    check("fresh_pass",     {31'd0, pass_a},   32'd1);

    // Three-input XOR gate, settle 3
    sweep(1'b1, 3'd4, 3'd0, 40, 0, done_cyc, ndone);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("xor_vec_%0d", i), {28'd0, vec_log[1 + 4 * i]}, 32'(i));
    end
    check("xor_done_cyc", done_cyc, 32'd33);
    check("xor_ndone",    ndone,    32'd1);
    check("xor_result",   {24'd0, result_b}, 32'h000000ff);
    check("xor_err",      {28'd0, err_b},    32'd0);
    check("xor_pass",     {31'd0, pass_b},   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
# gate_checker

Hardware self-checking harness for small combinational gates. It sweeps every input combination into a gate under test and waits a programmable settle time. It then samples the gate output and compares it against a built-in reference for the selected logic function. It records a per-vector pass bitmap and an error count, so gate-level blocks (AND, OR, ...) can be checked on-chip or in synthesizable benches instead of by reading printed truth tables.

## Interface
Parameters:
- N_IN, 2, number of gate inputs swept (1..4); vector count V = 2**N_IN
- SETTLE_CYCLES, 1, cycles each vector is held before sampling (>= 1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a sweep; sampled only in IDLE
- op  in  3  function under test, latched at start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved
- vec  out  N_IN  input vector driven to the gate under test (bit 0 → in1, bit 1 → in2, ...)
- dut_out  in  1  gate-under-test output
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  all vectors matched; valid from done until next start
- bad_op  out  1  latched op was reserved
- result  out  V  bit i = 1 if vector i matched
- err_count  out  N_IN+1  number of mismatching vectors

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: vec=0. On start=1:
  - latch op.
  - Clear result, err_count, pass and bad_op.
  - If op is reserved, go to DONE and set bad_op=1. Otherwise go to SETTLE with vec=0 and settle counter=0.
- SETTLE: hold vec. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE: compute expected = ref(op_latched, vec) and compare it with dut_out.
  - Set result[vec] to match. Increment err_count on mismatch.
  - If vec == V-1, go to DONE. Otherwise increment vec and return to SETTLE.
- Reference function for N_IN inputs:
  - AND/OR/XOR are the reductions over vec.
  - NAND/NOR/XNOR are their inverses.
- DONE: done=1 for one cycle. pass = (err_count==0) && !bad_op, using the final count. Go to IDLE.
- result, err_count, pass and bad_op hold after DONE until the next accepted start.
- start while busy, or while in DONE, is ignored. It is not queued.
- op changes after start have no effect.

## Timing
- Reset (rst_n=0 at a rising edge, any state, including mid-sweep):
  - state=IDLE, vec=0, busy=0, done=0, pass=0, bad_op=0, result=0, err_count=0.
  - A sweep cut short by reset is abandoned and produces no done pulse.
- Let S = SETTLE_CYCLES, with start sampled at edge 0.
  - Vector i is driven from cycle 1+i(S+1).
  - Vector i is sampled in cycle (i+1)(S+1).
  - done is high in cycle V(S+1)+1.
  - busy is high in cycles 1..V(S+1)+1.
- Reserved op: done and bad_op=1 in cycle 1, result=0, err_count=0, pass=0.
- dut_out is sampled at the rising edge ending the SAMPLE cycle. The gate path must settle within S cycles.
- err_count width N_IN+1 holds V without wrap. The vec increment never wraps, because the sweep ends at V-1.

## Structure
- Package gate_pkg:
  - op code constants OP_AND..OP_XNOR.
  - state enum.
  - function gate_expected(op, vec) returning the reference bit.
- Optional sub-module gate_ref: a combinational reference model wrapping gate_expected, reusable by other gate benches.
- The top block holds the FSM, settle counter, vec counter and result registers.

## Test plan
- AND gate (in1=vec[0], in2=vec[1]), op=0, S=1 → vec sequence 0,1,2,3, done at cycle 9, result=4'b1111, err_count=0, pass=1.
- Same AND gate with op=1 (OR) → result=4'b1001 (vectors 1,2 mismatch), err_count=2, pass=0.
- dut_out tied to 1, op=2 (NAND) → result=4'b0111, err_count=1; start pulsed mid-sweep is ignored and done occurs exactly once.
- op=6 → done in cycle 1, bad_op=1, pass=0, result=0, vec stays 0.
- Reset asserted in the SETTLE phase of vector 2 → next edge all outputs 0, no done; a fresh start then completes normally with pass=1.
- N_IN=3, S=3, XOR gate, op=4 → 8 vectors, done at cycle 33, result=8'hFF, err_count=0.
